cfg_req_ctrl: RTL and testbench

Sequencer between the transaction-layer receive path and the configuration register file. Accepts one decoded Configuration Request (CfgRd0/CfgWr0/Type1) at a time, performs the single-cycle register access via the `cfg_*` strobe interface, and emits a completion descriptor (Cpl or CplD) to the TL transmit scheduler over a valid/ready handshake. Strictly one outstanding request, per the non-posted config ordering rules.

---
 rtl/cfg_req_ctrl.sv | 147 ++++++++++++++
 tb/tb_cfg_req_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_req_ctrl.sv
// Configuration request sequencer: accepts one config request, performs the
// single-cycle register-file access and returns a Cpl/CplD descriptor.
module cfg_req_ctrl #(
  parameter int unsigned ADDR_DW_MAX  = 63,
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_wr,
  input  logic        req_type1,
  input  logic [9:0]  req_reg_dw,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [15:0] req_requester_id,
  input  logic [7:0]  req_tag,
  output logic        cfg_rd_en,
  output logic        cfg_wr_en,
  output logic [9:0]  cfg_addr_dw,
  output logic [31:0] cfg_wdata,
  output logic [3:0]  cfg_be,
  input  logic [31:0] cfg_rdata,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [2:0]  cpl_status,
  output logic        cpl_has_data,
  output logic [31:0] cpl_data,
  output logic [11:0] cpl_byte_count,
  output logic [6:0]  cpl_lower_addr,
  output logic [15:0] cpl_requester_id,
  output logic [7:0]  cpl_tag,
  output logic [15:0] cpl_completer_id,
  output logic        busy
);

  localparam logic [9:0] LP_MAX_DW = 10'(ADDR_DW_MAX);
  localparam logic [2:0] LP_SC     = 3'b000;
  localparam logic [2:0] LP_UR     = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_CPL    = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_is_wr;
  logic        r_type1;
  logic [9:0]  r_reg_dw;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [15:0] r_rid;
  logic [7:0]  r_tag;
  logic [2:0]  r_cpl_status;
  logic        r_cpl_has_data;
  logic [31:0] r_cpl_data;

  logic w_err;
  logic w_access;
  logic w_rd;
  logic w_wr;

  // Strobes are decoded from the state register, so an async reset kills them at once
  always_comb begin
    w_err    = 1'b0;
    w_access = 1'b0;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    if (r_state == S_ACCESS) begin
      w_access = 1'b1;
      w_err    = r_type1 | (r_reg_dw > LP_MAX_DW);
      w_rd     = ~w_err & ~r_is_wr;
      w_wr     = ~w_err & r_is_wr;
    end else begin
      w_access = 1'b0;
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign busy             = (r_state != S_IDLE);
  assign cpl_valid        = (r_state == S_CPL);
  assign cfg_rd_en        = w_rd;
  assign cfg_wr_en        = w_wr;
  assign cfg_addr_dw      = r_reg_dw;
  assign cfg_wdata        = r_wdata;
  assign cfg_be           = r_be;
  assign cpl_status       = r_cpl_status;
  assign cpl_has_data     = r_cpl_has_data;
  assign cpl_data         = r_cpl_data;
  assign cpl_byte_count   = 12'd4;
  assign cpl_lower_addr   = 7'd0;
  assign cpl_requester_id = r_rid;
  assign cpl_tag          = r_tag;
  assign cpl_completer_id = COMPLETER_ID;

  // Request sequencer: latch, access, then hold the completion until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_is_wr        <= 1'b0;
      r_type1        <= 1'b0;
      r_reg_dw       <= 10'd0;
      r_be           <= 4'd0;
      r_wdata        <= 32'd0;
      r_rid          <= 16'd0;
      r_tag          <= 8'd0;
      r_cpl_status   <= 3'd0;
      r_cpl_has_data <= 1'b0;
      r_cpl_data     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_wr  <= req_is_wr;
            r_type1  <= req_type1;
            r_reg_dw <= req_reg_dw;
            r_be     <= req_be;
            r_wdata  <= req_wdata;
            r_rid    <= req_requester_id;
            r_tag    <= req_tag;
            r_state  <= S_ACCESS;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_cpl_status   <= w_err ? LP_UR : LP_SC;
          r_cpl_has_data <= w_rd;
          r_cpl_data     <= w_rd ? cfg_rdata : 32'd0;
          r_state        <= S_CPL;
        end
        S_CPL: begin
          if (cpl_ready) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CPL;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_req_ctrl.sv
// Directed bench for cfg_req_ctrl with a small register-file model and a
// completion scoreboard.
module tb_cfg_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_wr;
  logic        req_type1;
  logic [9:0]  req_reg_dw;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [15:0] req_requester_id;
  logic [7:0]  req_tag;
  logic        cfg_rd_en;
  logic        cfg_wr_en;
  logic [9:0]  cfg_addr_dw;
  logic [31:0] cfg_wdata;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_rdata;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [2:0]  cpl_status;
  logic        cpl_has_data;
  logic [31:0] cpl_data;
  logic [11:0] cpl_byte_count;
  logic [6:0]  cpl_lower_addr;
  logic [15:0] cpl_requester_id;
  logic [7:0]  cpl_tag;
  logic [15:0] cpl_completer_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic        hd;
    logic [31:0] d;
    logic [15:0] rid;
    logic [7:0]  tag;
  } exp_t;
  exp_t q[$];

  logic [31:0] regs [0:63];
  logic        init_done;

  cfg_req_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_wr(req_is_wr),
    .req_type1(req_type1), .req_reg_dw(req_reg_dw), .req_be(req_be),
    .req_wdata(req_wdata), .req_requester_id(req_requester_id), .req_tag(req_tag),
    .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en), .cfg_addr_dw(cfg_addr_dw),
    .cfg_wdata(cfg_wdata), .cfg_be(cfg_be), .cfg_rdata(cfg_rdata),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_status(cpl_status),
    .cpl_has_data(cpl_has_data), .cpl_data(cpl_data),
    .cpl_byte_count(cpl_byte_count), .cpl_lower_addr(cpl_lower_addr),
    .cpl_requester_id(cpl_requester_id), .cpl_tag(cpl_tag),
    .cpl_completer_id(cpl_completer_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, byte-enabled write
  assign cfg_rdata = (cfg_addr_dw < 10'd64) ? regs[cfg_addr_dw[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) regs[i] <= 32'h0;
      regs[0] <= 32'hABCD1234;
      regs[4] <= 32'hFFFFFFFF;
      regs[5] <= 32'h55AA55AA;
    end else if (cfg_wr_en && cfg_addr_dw < 10'd64) begin
      for (int b = 0; b < 4; b++)
        if (cfg_be[b]) regs[cfg_addr_dw[5:0]][8*b +: 8] <= cfg_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the CPL cycle
  task automatic drive_req(input logic is_wr, input logic t1, input logic [9:0] dw,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [15:0] rid, input logic [7:0] tag,
                           input logic [2:0] est, input logic ehd, input logic [31:0] ed);
    int n;
    exp_t e;
    req_is_wr = is_wr; req_type1 = t1; req_reg_dw = dw; req_be = be;
    req_wdata = wd; req_requester_id = rid; req_tag = tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $error("FAIL req_accept timeout observed=0 expected=1");
    end
    e.st = est; e.hd = ehd; e.d = ed; e.rid = rid; e.tag = tag;
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("acc_rd_en", cfg_rd_en, (!is_wr && est == 3'b000));
    chk("acc_wr_en", cfg_wr_en, (is_wr && est == 3'b000));
    chk("acc_addr", cfg_addr_dw, dw);
    if (is_wr) begin
      chk("acc_be", cfg_be, be);
      chk("acc_wdata", cfg_wdata, wd);
    end
    chk("acc_req_ready", req_ready, 1'b0);
    chk("acc_cpl_valid", cpl_valid, 1'b0);
    @(negedge clk);
    chk("cpl_valid_t2", cpl_valid, 1'b1);
    chk("cpl_strobes", {cfg_rd_en, cfg_wr_en}, 2'b00);
    chk("cpl_req_ready", req_ready, 1'b0);
  endtask

  task automatic finish_cpl();
    exp_t e;
    cpl_ready = 1'b1;
    chk("fin_cpl_valid", cpl_valid, 1'b1);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk("cpl_status", cpl_status, e.st);
      chk("cpl_has_data", cpl_has_data, e.hd);
      chk("cpl_data", cpl_data, e.d);
      chk("cpl_rid", cpl_requester_id, e.rid);
      chk("cpl_tag", cpl_tag, e.tag);
      chk("cpl_bc", cpl_byte_count, 12'd4);
      chk("cpl_la", cpl_lower_addr, 7'd0);
      chk("cpl_cid", cpl_completer_id, 16'h0100);
    end
    @(negedge clk);
    cpl_ready = 1'b0;
    chk("post_cpl_valid", cpl_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0;
    req_valid = 1'b0; req_is_wr = 1'b0; req_type1 = 1'b0; req_reg_dw = 10'd0;
    req_be = 4'd0; req_wdata = 32'd0; req_requester_id = 16'd0; req_tag = 8'd0;
    cpl_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    init_done = 1'b1;
    chk("rst_cpl_valid", cpl_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {cfg_rd_en, cfg_wr_en}, 2'b00);
    chk("rst_addr", cfg_addr_dw, 10'd0);
    chk("rst_tag", cpl_tag, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);

    // Read DW0
    drive_req(1'b0, 1'b0, 10'd0, 4'hF, 32'd0, 16'h0200, 8'h05, 3'b000, 1'b1, 32'hABCD1234);
    finish_cpl();

    // Partial write to DW4 then read back
    drive_req(1'b1, 1'b0, 10'd4, 4'b0011, 32'hDEADBEEF, 16'h0200, 8'h06, 3'b000, 1'b0, 32'h0);
    finish_cpl();
    drive_req(1'b0, 1'b0, 10'd4, 4'hF, 32'd0, 16'h0200, 8'h07, 3'b000, 1'b1, 32'hFFFFBEEF);
    finish_cpl();

    // Backpressure with the next request held
    drive_req(1'b0, 1'b0, 10'd0, 4'hF, 32'd0, 16'h0300, 8'h08, 3'b000, 1'b1, 32'hABCD1234);
    req_is_wr = 1'b0; req_type1 = 1'b0; req_reg_dw = 10'd4; req_be = 4'hF;
    req_requester_id = 16'h0300; req_tag = 8'h09; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", cpl_valid, 1'b1);
      chk("bp_tag", cpl_tag, 8'h08);
      chk("bp_data", cpl_data, 32'hABCD1234);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_strobes", {cfg_rd_en, cfg_wr_en}, 2'b00);
    end
    finish_cpl();
    chk("bp_next_ready", req_ready, 1'b1);
    drive_req(1'b0, 1'b0, 10'd4, 4'hF, 32'd0, 16'h0300, 8'h09, 3'b000, 1'b1, 32'hFFFFBEEF);
    finish_cpl();

    // Unsupported requests
    drive_req(1'b0, 1'b0, 10'd64, 4'hF, 32'd0, 16'h0400, 8'h0A, 3'b001, 1'b0, 32'h0);
    finish_cpl();
    drive_req(1'b0, 1'b1, 10'd0, 4'hF, 32'd0, 16'h0400, 8'h0B, 3'b001, 1'b0, 32'h0);
    finish_cpl();

    // Zero byte-enable write leaves DW5 intact
    drive_req(1'b1, 1'b0, 10'd5, 4'b0000, 32'h12345678, 16'h0500, 8'h0C, 3'b000, 1'b0, 32'h0);
    finish_cpl();
    drive_req(1'b0, 1'b0, 10'd5, 4'hF, 32'd0, 16'h0500, 8'h0C, 3'b000, 1'b1, 32'h55AA55AA);
    finish_cpl();

    // cpl_ready while idle is ignored
    cpl_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_rdy_valid", cpl_valid, 1'b0);
      chk("idle_rdy_busy", busy, 1'b0);
    end
    cpl_ready = 1'b0;
    @(negedge clk);

    // Reset during CPL
    drive_req(1'b0, 1'b0, 10'd0, 4'hF, 32'd0, 16'h0600, 8'h0D, 3'b000, 1'b1, 32'hABCD1234);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", cpl_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_strobes", {cfg_rd_en, cfg_wr_en}, 2'b00);
    if (q.size() > 0) void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    cpl_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", cpl_valid, 1'b0);
      chk("post_rst_strobes", {cfg_rd_en, cfg_wr_en}, 2'b00);
    end
    cpl_ready = 1'b0;
    drive_req(1'b0, 1'b0, 10'd0, 4'hF, 32'd0, 16'h0600, 8'h0E, 3'b000, 1'b1, 32'hABCD1234);
    finish_cpl();

    chk("sb_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
